// File: rtl/seq_restoring_divider_pkg.sv
// ---------------------------------------------------------------------------
// div_defs : shared definitions for the iterative restoring divider.
//   DIV_WIDTH     default operand / quotient / remainder width
//   DIV_CNT_W     default iteration counter width
//   div_state_e   FSM state encoding (IDLE / CALC / DONE)
//   QUOT_ALL_ONES quotient reported for a divide-by-zero
// ---------------------------------------------------------------------------
package div_defs;

  localparam int DIV_WIDTH = 6;
  localparam int DIV_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] QUOT_ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_trial_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub : combinational WIDTH-bit trial subtractor, a - b computed as
// a + ~b + 1.
//   a_i          minuend (shifted partial remainder)
//   b_i          subtrahend (divisor)
//   diff_o       a - b modulo 2**WIDTH
//   no_borrow_o  carry-out of the MSB; 1 when a >= b
// ---------------------------------------------------------------------------
module div_trial_sub #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             no_borrow_o
);

  logic [WIDTH:0] sum_s;

  // One extra bit carries the borrow-out of the two's-complement subtract.
  assign sum_s       = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_o      = sum_s[WIDTH-1:0];
  assign no_borrow_o = sum_s[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider : multi-cycle unsigned restoring divider, one
// quotient bit per clock. Start/done handshake.
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        request, sampled only in IDLE
//   dividend     captured on an accepted start
//   divisor      captured on an accepted start
//   quotient     result quotient, valid from done, held until next start
//   remainder    result remainder, valid from done, held until next start
//   busy         high in CALC and DONE
//   done         one-cycle result-valid pulse
//   div_by_zero  set together with done when the captured divisor was 0
// ---------------------------------------------------------------------------
module seq_restoring_divider
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] Q_ALL_ONES =
    (WIDTH == DIV_WIDTH) ? WIDTH'(QUOT_ALL_ONES) : {WIDTH{1'b1}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic             dbz_q,   dbz_d;

  // Shifted partial remainder: r_hi is the bit shifted out of R, giving the
  // trial subtract a (WIDTH+1)-bit minuend without widening the subtractor.
  logic             r_hi_s;
  logic [WIDTH-1:0] rs_s;
  logic [WIDTH-1:0] diff_s;
  logic             no_borrow_s;

  assign r_hi_s = r_q[WIDTH-1];
  assign rs_s   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .a_i         (rs_s),
    .b_i         (dvs_q),
    .diff_o      (diff_s),
    .no_borrow_o (no_borrow_s)
  );

  // State, counter and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          cnt_d = CNT_W'(WIDTH);
          if (divisor == {WIDTH{1'b0}}) begin
            q_d     = Q_ALL_ONES;
            r_d     = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            q_d     = dividend;
            r_d     = {WIDTH{1'b0}};
            dbz_d   = 1'b0;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // A set r_hi means the minuend is >= 2**WIDTH > divisor, so the
        // subtract always succeeds and diff (mod 2**WIDTH) is exact.
        if (r_hi_s || no_borrow_s) begin
          r_d = diff_s;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rs_s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// Self-checking bench for seq_restoring_divider (WIDTH=6). Expected results
// come from plain integer division in the bench; a table of known vectors is
// followed by hand-written corner sequences, an exhaustive sweep and a
// randomized run with idle gaps.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 6;
  localparam int CALC_LAT = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. Optionally pulses a second start
  // (10/2) at CALC observation inj_at, which must be ignored.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input string tag, input int inj_at);
    int lat;
    int exp_lat;
    exp_lat  = (b == 0) ? 0 : CALC_LAT;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = -1;
    for (int n = 0; n <= 20; n++) begin
      chk({tag, " busy"}, busy, 1);
      if (done) begin
        lat = n;
        break;
      end
      if (n == inj_at) begin
        start    = 1'b1;
        dividend = 6'd10;
        divisor  = 6'd2;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, div_by_zero, ez);
    step();
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " q hold"}, quotient, eq);
    chk({tag, " r hold"}, remainder, er);
    chk({tag, " dbz hold"}, div_by_zero, ez);
  endtask

  task automatic model_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = (b == 0) ? 6'd63 : a / b;
    er = (b == 0) ? a : a % b;
    do_div(a, b, eq, er, (b == 0), tag, -1);
  endtask

  initial begin
    vecs[0] = '{a: 6'd45, b: 6'd7,  q: 6'd6,  r: 6'd3,  z: 1'b0};
    vecs[1] = '{a: 6'd63, b: 6'd1,  q: 6'd63, r: 6'd0,  z: 1'b0};
    vecs[2] = '{a: 6'd5,  b: 6'd9,  q: 6'd0,  r: 6'd5,  z: 1'b0};
    vecs[3] = '{a: 6'd40, b: 6'd0,  q: 6'd63, r: 6'd40, z: 1'b1};
    vecs[4] = '{a: 6'd12, b: 6'd5,  q: 6'd2,  r: 6'd2,  z: 1'b0};
    vecs[5] = '{a: 6'd0,  b: 6'd5,  q: 6'd0,  r: 6'd0,  z: 1'b0};
    vecs[6] = '{a: 6'd63, b: 6'd63, q: 6'd1,  r: 6'd0,  z: 1'b0};
    vecs[7] = '{a: 6'd1,  b: 6'd63, q: 6'd0,  r: 6'd1,  z: 1'b0};
    vecs[8] = '{a: 6'd62, b: 6'd32, q: 6'd1,  r: 6'd30, z: 1'b0};
    vecs[9] = '{a: 6'd0,  b: 6'd0,  q: 6'd63, r: 6'd0,  z: 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 6'd0;
    divisor  = 6'd0;
    repeat (3) step();
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    reset = 1'b0;
    step();

    // Known vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
             $sformatf("vec%0d", i), -1);
    end

    // Start pulse during CALC cycle 3 must be ignored.
    do_div(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, "ignored start", 2);

    // Divide-by-zero first so dbz is set, then reset in CALC cycle 2.
    do_div(6'd40, 6'd0, 6'd63, 6'd40, 1'b1, "dbz pre-reset", -1);
    dividend = 6'd45;
    divisor  = 6'd7;
    start    = 1'b1;
    step();
    start    = 1'b0;
    step();
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    chk("midcalc reset quotient", quotient, 0);
    chk("midcalc reset remainder", remainder, 0);
    chk("midcalc reset busy", busy, 0);
    chk("midcalc reset done", done, 0);
    chk("midcalc reset dbz", div_by_zero, 0);
    do_div(6'd20, 6'd3, 6'd6, 6'd2, 1'b0, "after reset", -1);

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        model_div(W'(a), W'(b), "sweep");
      end
    end

    // Randomized operands with random idle gaps between requests.
    for (int k = 0; k < 200; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 63));
      rb = ($urandom_range(0, 7) == 0) ? 6'd0 : W'($urandom_range(1, 63));
      repeat ($urandom_range(0, 2)) step();
      model_div(ra, rb, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
